sd_blk_arbiter: RTL

//  Shares the single host SD block port (lba/rd/wr/ack/buff) between NREQ disk controllers
//  (FDC drives, MSX-DOS/Nextor HDD) in the cartridge slots. Round-robin grant; one block transfer
//  (rd or wr) owns the port from issue to ack fall. Sits between the cart controllers and the HPS/host bridge.

---
 rtl/sd_arb_pkg.sv | 20 ++
 rtl/sd_rr_pick.sv | 40 ++++
 rtl/sd_blk_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD block-port arbiter (sd_blk_arbiter).
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int NREQ_MAX    = 8;
  localparam int TMO_W       = 24;
  localparam int TMO_CYC_DEF = 1 << TMO_W;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational round-robin pick: first pending requester at or after ptr, wrapping.
module sd_rr_pick
  import sd_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  localparam logic [IW:0] NREQ_V = (IW + 1)'(NREQ);

  logic [2*NREQ-1:0] pend2;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     ofs;
  logic [IW:0]       sum;

  // Rotating the doubled vector puts requester ptr at bit 0, so a plain
  // lowest-set-bit search gives the round-robin order.
  assign pend2 = {pending, pending};
  assign rot   = NREQ'(pend2 >> ptr);
  assign valid = |rot;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    ofs = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) ofs = IW'(k);
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, ofs};
    idx = (sum >= NREQ_V) ? IW'(sum - NREQ_V) : IW'(sum);
  end

endmodule

// File: rtl/sd_blk_arbiter.sv
// Round-robin sharing of the host SD block port between NREQ disk controllers.
// Optional transfer watchdog enabled by defining SDARB_TIMEOUT_EN.
module sd_blk_arbiter
  import sd_arb_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int LBA_W   = 32,
`ifdef SDARB_TIMEOUT_EN
  parameter  int TMO_CYC = TMO_CYC_DEF,
`endif
  localparam int IW      = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ*LBA_W-1:0] req_lba,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  output logic [NREQ-1:0]       req_ack,
  input  logic [NREQ*8-1:0]     req_buff_din,
  output logic [NREQ-1:0]       req_buff_wr,
  output logic [NREQ-1:0]       req_err,
  output logic [LBA_W-1:0]      sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  output logic [IW-1:0]         sd_dev,
  input  logic                  sd_ack,
  input  logic                  sd_buff_wr,
  output logic [7:0]            sd_buff_din
);

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, grant, pick_idx;
  logic            pick_valid, op_rd, owned, grant_start;
  logic            tmo_hit, tmo_pulse;
  logic [NREQ-1:0] pending;

  logic [LBA_W-1:0] lba_arr [NREQ];
  logic [7:0]       din_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign lba_arr[i] = req_lba[i*LBA_W +: LBA_W];
    assign din_arr[i] = req_buff_din[i*8 +: 8];
  end

  assign pending     = req_rd | req_wr;
  assign owned       = (state == ST_ISSUE) || (state == ST_XFER);
  assign grant_start = (state == ST_IDLE) && (state_nx == ST_ISSUE);
  assign sd_dev      = grant;

  sd_rr_pick #(.NREQ(NREQ)) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // IDLE refuses to issue while the host still holds ack, which covers an
  // ack left over from a transfer cut short by reset.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (pick_valid && !sd_ack) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (tmo_hit)                state_nx = ST_DRAIN;
        else if (sd_ack)            state_nx = ST_XFER;
        else if (!pending[grant])   state_nx = ST_IDLE;
      end
      ST_XFER:  if (tmo_hit || !sd_ack) state_nx = ST_DRAIN;
      ST_DRAIN: if (!sd_ack) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    req_ack     = '0;
    req_buff_wr = '0;
    sd_buff_din = 8'hFF;
    if (state == ST_ISSUE) begin
      sd_rd = op_rd;
      sd_wr = !op_rd;
    end
    if (owned) begin
      req_ack[grant]     = sd_ack;
      req_buff_wr[grant] = sd_buff_wr;
      sd_buff_din        = din_arr[grant];
    end
    if (tmo_pulse) req_ack[grant] = 1'b1;
  end

  // Pointer moves past the granted requester only after a completed or aborted
  // transfer; a cancelled issue leaves it where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant  <= '0;
      op_rd  <= 1'b0;
      sd_lba <= '0;
      ptr    <= '0;
    end else begin
      if (grant_start) begin
        grant  <= pick_idx;
        op_rd  <= req_rd[pick_idx];
        sd_lba <= lba_arr[pick_idx];
      end
      if (state == ST_DRAIN && state_nx == ST_IDLE)
        ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
    end
  end

`ifdef SDARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = owned && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      tmo_pulse <= 1'b0;
      req_err   <= '0;
    end else begin
      tmo_pulse <= tmo_hit;
      tmo_cnt   <= (owned && !tmo_hit) ? tmo_cnt + TMO_W'(1) : '0;
      if (grant_start) req_err[pick_idx] <= 1'b0;
      if (tmo_hit)     req_err[grant]    <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign tmo_pulse = 1'b0;
  assign req_err   = '0;
`endif

endmodule
